// File: rtl/imem_icache_if.sv
// Word-wide instruction memory read bus: req/gnt address phase, rvalid data phase.
// The cache is the master; the memory (or its model) is the slave.
interface imem_icache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [INST_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/imem_icache.sv
// Direct-mapped read-only instruction cache: one-cycle hits, whole-line refill
// with a single outstanding memory read, and whole-cache invalidation for fence.i.
module imem_icache #(
  parameter int ADDR_WIDTH     = 32,
  parameter int INST_WIDTH     = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_read,
  output logic [INST_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  inv,
  imem_icache_if.master         mem
);
  localparam int OFF   = $clog2(WORDS_PER_LINE);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - 2 - OFF - IDX;
  localparam int NW    = LINES * WORDS_PER_LINE;
  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [TAG_W-1:0]      tag_q [LINES];
  logic [TAG_W-1:0]      tag_d [LINES];
  logic [INST_WIDTH-1:0] data_q [NW];
  logic [INST_WIDTH-1:0] data_d [NW];
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]      ltag_q, ltag_d;
  logic [IDX-1:0]        lidx_q, lidx_d;
  logic [OFF-1:0]        loff_q, loff_d;
  logic [OFF-1:0]        cnt_q, cnt_d;
  logic                  inv_pend_q, inv_pend_d;
  logic [INST_WIDTH-1:0] rdata_q, rdata_d;
  logic                  stall_q, stall_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;

  logic [OFF-1:0]   c_off;
  logic [IDX-1:0]   c_idx;
  logic [TAG_W-1:0] c_tag;
  logic             hit_s;
  logic [OFF-1:0]   cnt_inc_s;
  logic             unused_addr_bits;

  assign c_off            = cpu_addr[2 +: OFF];
  assign c_idx            = cpu_addr[2+OFF +: IDX];
  assign c_tag            = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign hit_s            = valid_q[c_idx] && (tag_q[c_idx] == c_tag);
  assign cnt_inc_s        = cnt_q + OFF'(1);
  assign unused_addr_bits = ^cpu_addr[1:0];

  // Next-state, refill bookkeeping and registered-output computation
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ltag_d     = ltag_q;
    lidx_d     = lidx_q;
    loff_d     = loff_q;
    cnt_d      = cnt_q;
    inv_pend_d = inv_pend_q;
    rdata_d    = rdata_q;
    stall_d    = stall_q;
    req_d      = req_q;
    maddr_d    = maddr_q;
    case (state_q)
      IDLE, RESP: begin
        state_d    = IDLE;
        stall_d    = 1'b0;
        inv_pend_d = 1'b0;
        if (cpu_read) begin
          if (hit_s) begin
            rdata_d = data_q[{c_idx, c_off}];
          end else begin
            ltag_d  = c_tag;
            lidx_d  = c_idx;
            loff_d  = c_off;
            cnt_d   = '0;
            state_d = REQ;
            stall_d = 1'b1;
            req_d   = 1'b1;
            maddr_d = {c_tag, c_idx, {OFF{1'b0}}, 2'b00};
          end
        end else begin
          rdata_d = rdata_q;
        end
        // Hit lookup above used the pre-invalidation valid bits.
        if (inv) begin
          valid_d = '0;
        end else begin
          valid_d = valid_q;
        end
      end
      REQ: begin
        stall_d = 1'b1;
        if (inv) begin
          inv_pend_d = 1'b1;
        end else begin
          inv_pend_d = inv_pend_q;
        end
        if (mem.mem_gnt) begin
          req_d   = 1'b0;
          state_d = WAIT;
        end else begin
          req_d   = 1'b1;
        end
      end
      WAIT: begin
        stall_d = 1'b1;
        if (inv) begin
          inv_pend_d = 1'b1;
        end else begin
          inv_pend_d = inv_pend_q;
        end
        if (mem.mem_rvalid) begin
          data_d[{lidx_q, cnt_q}] = mem.mem_rdata;
          if (&cnt_q) begin
            tag_d[lidx_q] = ltag_q;
            if (inv_pend_q || inv) begin
              valid_d = '0;
            end else begin
              valid_d[lidx_q] = 1'b1;
            end
            inv_pend_d = 1'b0;
            state_d    = RESP;
            stall_d    = 1'b0;
            rdata_d    = data_d[{lidx_q, loff_q}];
          end else begin
            cnt_d   = cnt_inc_s;
            state_d = REQ;
            req_d   = 1'b1;
            maddr_d = {ltag_q, lidx_q, cnt_inc_s, 2'b00};
          end
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and outputs; reset abandons any in-flight refill
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      ltag_q     <= '0;
      lidx_q     <= '0;
      loff_q     <= '0;
      cnt_q      <= '0;
      inv_pend_q <= 1'b0;
      rdata_q    <= NOP;
      stall_q    <= 1'b0;
      req_q      <= 1'b0;
      maddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      ltag_q     <= ltag_d;
      lidx_q     <= lidx_d;
      loff_q     <= loff_d;
      cnt_q      <= cnt_d;
      inv_pend_q <= inv_pend_d;
      rdata_q    <= rdata_d;
      stall_q    <= stall_d;
      req_q      <= req_d;
      maddr_q    <= maddr_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign cpu_rdata    = rdata_q;
  assign cpu_stall    = stall_q;
  assign mem.mem_req  = req_q;
  assign mem.mem_addr = maddr_q;
endmodule

// File: tb/tb_imem_icache.sv
// Directed bench for imem_icache with a behavioural memory whose grant and
// rvalid latencies are adjustable per test.
module tb_imem_icache;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic [31:0] cpu_addr = 32'h0000_0000;
  logic        cpu_read = 1'b0;
  logic        inv      = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  imem_icache_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

  imem_icache #(
    .ADDR_WIDTH(32), .INST_WIDTH(32), .LINES(16), .WORDS_PER_LINE(4)
  ) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_read(cpu_read),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .inv(inv), .mem(bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Memory model state
  int          gnt_dly = 0;
  int          rv_dly  = 1;
  int          gwait   = 0;
  int          rv_cnt  = 0;
  int          addr_bad = 0;
  bit          holding = 1'b0;
  logic [31:0] held_addr = 32'h0;
  logic [31:0] rv_addr = 32'h0;
  logic [31:0] gnt_addrs[$];
  logic        model_gnt = 1'b0;
  logic        model_rv  = 1'b0;
  logic        stray_rv  = 1'b0;
  logic [31:0] model_rdata = 32'h0;

  assign bus.mem_gnt    = model_gnt;
  assign bus.mem_rvalid = model_rv | stray_rv;
  assign bus.mem_rdata  = stray_rv ? 32'hDEAD_BEEF : model_rdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      model_gnt = 1'b0;
      model_rv  = 1'b0;
      if (rst) begin
        rv_cnt  = 0;
        gwait   = 0;
        holding = 1'b0;
      end else if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          model_rv    = 1'b1;
          model_rdata = mem_word(rv_addr);
        end
      end else if (bus.mem_req) begin
        if (!holding) begin
          holding   = 1'b1;
          held_addr = bus.mem_addr;
        end else if (bus.mem_addr !== held_addr) begin
          addr_bad++;
        end
        if (gwait < gnt_dly) begin
          gwait++;
        end else begin
          model_gnt = 1'b1;
          gwait     = 0;
          rv_addr   = bus.mem_addr;
          rv_cnt    = rv_dly;
          holding   = 1'b0;
          gnt_addrs.push_back(bus.mem_addr);
        end
      end
    end
  end

  // One fetch; returns how many sampled cycles showed stall, then the word.
  task automatic do_fetch(input logic [31:0] a, output int stalls, output logic [31:0] word);
    gnt_addrs.delete();
    cpu_addr = a;
    cpu_read = 1'b1;
    @(negedge clk);
    cpu_read = 1'b0;
    stalls = 0;
    while (cpu_stall === 1'b1 && stalls < 300) begin
      stalls++;
      @(negedge clk);
    end
    word = cpu_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_read = 1'b1; cpu_addr = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (cpu_rdata !== NOP) $display("FAIL reset_rdata got=%h exp=%h", cpu_rdata, NOP); else passed++;
    checks++; if (cpu_stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", cpu_stall); else passed++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", bus.mem_req); else passed++;
    checks++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_maddr got=%h exp=0", bus.mem_addr); else passed++;
    rst = 1'b0; cpu_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_miss();
    int n; logic [31:0] w; int sz;
    do_fetch(32'h0000_0000, n, w);
    sz = gnt_addrs.size();
    checks++; if (n !== 8) $display("FAIL miss_stalls got=%0d exp=8", n); else passed++;
    checks++; if (w !== mem_word(32'h0)) $display("FAIL miss_word got=%h exp=%h", w, mem_word(32'h0)); else passed++;
    checks++; if (sz !== 4) $display("FAIL miss_ngrants got=%0d exp=4", sz); else passed++;
    for (int i = 0; i < 4 && i < sz; i++) begin
      checks++;
      if (gnt_addrs[i] !== 32'(i * 4)) $display("FAIL miss_addr%0d got=%h exp=%h", i, gnt_addrs[i], 32'(i * 4));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] req_a [3];
    logic [31:0] exp_a [3];
    req_a[0] = 32'h0000_0004; req_a[1] = 32'h0000_000B; req_a[2] = 32'h0000_000C;
    exp_a[0] = 32'h0000_0004; exp_a[1] = 32'h0000_0008; exp_a[2] = 32'h0000_000C;
    cpu_addr = req_a[0]; cpu_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (cpu_rdata !== mem_word(exp_a[i])) $display("FAIL b2b_word%0d got=%h exp=%h", i, cpu_rdata, mem_word(exp_a[i])); else passed++;
      checks++; if (cpu_stall !== 1'b0) $display("FAIL b2b_stall%0d got=%b exp=0", i, cpu_stall); else passed++;
      checks++; if (bus.mem_req !== 1'b0) $display("FAIL b2b_req%0d got=%b exp=0", i, bus.mem_req); else passed++;
      if (i < 2) cpu_addr = req_a[i+1];
      else cpu_read = 1'b0;
    end
    cpu_addr = 32'h0000_0400;
    @(negedge clk);
    checks++; if (cpu_rdata !== mem_word(32'hC)) $display("FAIL idle_hold got=%h exp=%h", cpu_rdata, mem_word(32'hC)); else passed++;
  endtask

  task automatic test_alias();
    int n; logic [31:0] w;
    do_fetch(32'h0000_0408, n, w);
    checks++; if (n !== 8) $display("FAIL alias_stalls got=%0d exp=8", n); else passed++;
    checks++; if (w !== mem_word(32'h408)) $display("FAIL alias_word got=%h exp=%h", w, mem_word(32'h408)); else passed++;
    checks++; if (gnt_addrs.size() != 4 || gnt_addrs[0] !== 32'h400 || gnt_addrs[3] !== 32'h40C)
      $display("FAIL alias_addrs got_n=%0d exp=4 (0x400..0x40C)", gnt_addrs.size()); else passed++;
    do_fetch(32'h0000_0000, n, w);
    checks++; if (n !== 8) $display("FAIL evict_stalls got=%0d exp=8", n); else passed++;
    checks++; if (w !== mem_word(32'h0)) $display("FAIL evict_word got=%h exp=%h", w, mem_word(32'h0)); else passed++;
  endtask

  task automatic test_inv_pending();
    int n; logic [31:0] w;
    cpu_addr = 32'h0000_0024; cpu_read = 1'b1;
    @(negedge clk);
    cpu_read = 1'b0;
    n = 0;
    while (cpu_stall === 1'b1 && n < 300) begin
      n++;
      inv = (n == 4);
      @(negedge clk);
    end
    inv = 1'b0;
    checks++; if (n !== 8) $display("FAIL invp_stalls got=%0d exp=8", n); else passed++;
    checks++; if (cpu_rdata !== mem_word(32'h24)) $display("FAIL invp_word got=%h exp=%h", cpu_rdata, mem_word(32'h24)); else passed++;
    do_fetch(32'h0000_0024, n, w);
    checks++; if (n !== 8) $display("FAIL invp_refetch_stalls got=%0d exp=8", n); else passed++;
    do_fetch(32'h0000_0024, n, w);
    checks++; if (n !== 0) $display("FAIL invp_hit_stalls got=%0d exp=0", n); else passed++;
    checks++; if (w !== mem_word(32'h24)) $display("FAIL invp_hit_word got=%h exp=%h", w, mem_word(32'h24)); else passed++;
  endtask

  task automatic test_inv_idle();
    int n; logic [31:0] w;
    cpu_addr = 32'h0000_0028; cpu_read = 1'b1; inv = 1'b1;
    @(negedge clk);
    cpu_read = 1'b0; inv = 1'b0;
    checks++; if (cpu_stall !== 1'b0) $display("FAIL invi_stall got=%b exp=0", cpu_stall); else passed++;
    checks++; if (cpu_rdata !== mem_word(32'h28)) $display("FAIL invi_word got=%h exp=%h", cpu_rdata, mem_word(32'h28)); else passed++;
    do_fetch(32'h0000_0028, n, w);
    checks++; if (n !== 8) $display("FAIL invi_refetch_stalls got=%0d exp=8", n); else passed++;
  endtask

  task automatic test_slow_memory();
    int n; logic [31:0] w;
    gnt_dly = 3; rv_dly = 2; addr_bad = 0;
    do_fetch(32'h0000_013C, n, w);
    checks++; if (n !== 4 * (3 + 1 + 2)) $display("FAIL slow_stalls got=%0d exp=%0d", n, 4 * (3 + 1 + 2)); else passed++;
    checks++; if (w !== mem_word(32'h13C)) $display("FAIL slow_word got=%h exp=%h", w, mem_word(32'h13C)); else passed++;
    checks++; if (addr_bad !== 0) $display("FAIL slow_addr_stable got=%0d exp=0", addr_bad); else passed++;
    checks++; if (gnt_addrs.size() != 4 || gnt_addrs[0] !== 32'h130 || gnt_addrs[3] !== 32'h13C)
      $display("FAIL slow_addrs got_n=%0d exp=4 (0x130..0x13C)", gnt_addrs.size()); else passed++;
    gnt_dly = 0; rv_dly = 1;
  endtask

  task automatic test_reset_midflight();
    int n; logic [31:0] w;
    rv_dly = 3;
    cpu_addr = 32'h0000_0050; cpu_read = 1'b1;
    @(negedge clk);
    cpu_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; stray_rv = 1'b1;
    @(negedge clk);
    stray_rv = 1'b0;
    checks++; if (cpu_stall !== 1'b0) $display("FAIL rstwait_stall got=%b exp=0", cpu_stall); else passed++;
    checks++; if (cpu_rdata !== NOP) $display("FAIL rstwait_rdata got=%h exp=%h", cpu_rdata, NOP); else passed++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL rstwait_req got=%b exp=0", bus.mem_req); else passed++;
    rv_dly = 1;
    do_fetch(32'h0000_0050, n, w);
    checks++; if (n !== 8) $display("FAIL rstwait_refetch_stalls got=%0d exp=8", n); else passed++;
    checks++; if (w !== mem_word(32'h50)) $display("FAIL rstwait_word got=%h exp=%h", w, mem_word(32'h50)); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_miss();
    test_back_to_back();
    test_alias();
    test_inv_pending();
    test_inv_idle();
    test_slow_memory();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
